regfile_ctx_engine: RTL
=======================

# regfile_ctx_engine

Context save/restore engine for the 16×16 register file. On command it either dumps every register to data memory (save) or reloads every register from data memory (restore). It drives the register file's port-d side (address, write enable, write data, read data) and masters a simple req/ack memory port. The processor uses it for interrupt entry/exit and task switch, and stalls while `busy` is high.

## Interface
- `NREGS`, 16: registers transferred, indices 0..NREGS-1; must be ≤ 2^RA_W.
- `RA_W`, 4: register address width.
- `DW`, 16: data width, for both register and memory data.
- `AW`, 16: memory address width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  command strobe, sampled only in IDLE.
- `dir`  in  1  0 = save (regfile→mem), 1 = restore (mem→regfile); sampled with `start`.
- `base_addr`  in  AW  memory address of register 0's slot; latched with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse in DONE.
- `rf_addr`  out  RA_W  register index presented to the register file.
- `rf_we`  out  1  register write enable.
- `rf_wdata`  out  DW  register write data.
- `rf_rdata`  in  DW  combinational read data for `rf_addr`.
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_we`  out  1  1 = memory write, 0 = memory read; valid while `mem_req` is high.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; valid in the `mem_ack` cycle.
- `mem_ack`  in  1  request complete; may be asserted in the same cycle as `mem_req` (zero-wait).

## Operation
- State: `idx` (RA_W+1 bits), data buffer `buf` (DW), latched `dir_q`, latched `base_q`. All outputs are registered.
- FSM states: IDLE, RD, MEM, WR, DONE.
- IDLE → RD when `start`=1 and `dir`=0. IDLE → MEM when `start`=1 and `dir`=1. On either transition `idx`←0 and `base_q`←`base_addr`.
- **Save path**
  - RD: `rf_addr`=`idx`. `buf` captures `rf_rdata` at the end of the cycle. Next state MEM.
  - MEM: `mem_req`=1, `mem_we`=1, `mem_addr`=`base_q`+`idx`, `mem_wdata`=`buf`. Stay in MEM until `mem_ack`=1.
  - On ack: if `idx`=NREGS-1, go to DONE; otherwise `idx`+1 and go to RD.
- **Restore path**
  - MEM: `mem_req`=1, `mem_we`=0, `mem_addr`=`base_q`+`idx`. On `mem_ack`, `buf`←`mem_rdata` and go to WR.
  - WR: `rf_addr`=`idx`, `rf_we`=1, `rf_wdata`=`buf`. The register file commits on the falling clock edge inside this cycle.
  - After WR: if `idx`=NREGS-1, go to DONE; otherwise `idx`+1 and go to MEM.
- DONE: `done`=1 and `busy`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^AW: `base_q`+`idx` wraps (0xFFFF+1 → 0x0000). No carry out, no error.
- `start` in any state other than IDLE is ignored and is not queued.
- `mem_ack` outside MEM is ignored.
- Changes to `base_addr` or `dir` during an operation have no effect.
- Register index order is always ascending 0..NREGS-1.

## Timing
- Reset (`rst`=0 at a rising edge) forces IDLE, `idx`=0, `buf`=0, and every output to 0. It overrides `start`.
- Reset mid-operation abandons the transfer immediately. `mem_req` drops on the next edge and memory must tolerate the abandoned request. Register or memory contents already written remain written.
- `rf_we` is never high for more than one consecutive cycle, and is never high in a save.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable while `mem_req`=1 and `mem_ack`=0.
- Latency with zero-wait memory (ack in the first MEM cycle): 2·NREGS+1 cycles from the edge accepting `start` to the end of DONE. That is 33 cycles for NREGS=16, for both save and restore.
- Each wait cycle on `mem_ack` adds exactly one cycle.
- `busy`=0 in the cycle after DONE. A new `start` is accepted in that same cycle.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `start`=1 → all outputs 0, FSM stays in IDLE. After release with `start`=0, nothing happens.
- Save, zero-wait: R0..R15 = 0x1000+i, `base_addr`=0x0200 → 16 memory writes, addr 0x0200+i and data 0x1000+i in ascending order. `done` pulses exactly 33 cycles after start. `rf_we` is never 1.
- Restore, 2-wait-cycle memory: mem[0x0300+i] = ~i → R0..R15 = 0xFFFF-i. `mem_req` held 3 cycles per access. `rf_we` pulses 16 times with one cycle each. Total 65 cycles.
- Wrap: save with `base_addr`=0xFFF8 → addresses 0xFFF8..0xFFFF, then 0x0000..0x0007.
- Start while busy: pulse `start` with `dir`=1 mid-save → ignored. Save completes unchanged and exactly one `done` pulse occurs.
- Reset mid-restore after R5 is written: `rst`=0 → `mem_req`=0 and `busy`=0 next cycle. R0..R5 keep their new values (if the register file itself is not reset). A new save afterwards starts at idx 0.

Source files
------------

// File: rtl/regfile_ctx_engine.sv
// Context save/restore engine: walks registers 0..NREGS-1 between the register file and data memory.
// Two cycles per register plus one DONE cycle; stalls in MEM for as long as mem_ack is held low.
module regfile_ctx_engine #(
  parameter int NREGS = 16,
  parameter int RA_W  = 4,
  parameter int DW    = 16,
  parameter int AW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dir,
  input  logic [AW-1:0]   base_addr,
  output logic            busy,
  output logic            done,
  output logic [RA_W-1:0] rf_addr,
  output logic            rf_we,
  output logic [DW-1:0]   rf_wdata,
  input  logic [DW-1:0]   rf_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_MEM  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [RA_W:0] LAST_IDX = (RA_W+1)'(NREGS - 1);
  localparam logic [RA_W:0] ONE_IDX  = (RA_W+1)'(1);

  logic [2:0]    state, nstate;
  logic [RA_W:0] idx, nidx;
  logic [DW-1:0] data_buf, nbuf;
  logic          dir_q, ndir;
  logic [AW-1:0] base_q, nbase;
  logic          last;

  logic            n_busy, n_done, n_rf_we, n_mem_req, n_mem_we;
  logic [RA_W-1:0] n_rf_addr;
  logic [DW-1:0]   n_rf_wdata, n_mem_wdata;
  logic [AW-1:0]   n_mem_addr;

  assign last = (idx == LAST_IDX);

  always_comb begin
    nstate = state;
    nidx   = idx;
    nbuf   = data_buf;
    ndir   = dir_q;
    nbase  = base_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          nidx   = '0;
          nbase  = base_addr;
          ndir   = dir;
          nstate = dir ? S_MEM : S_RD;
        end
      end
      S_RD: begin
        nbuf   = rf_rdata;
        nstate = S_MEM;
      end
      S_MEM: begin
        if (mem_ack) begin
          if (dir_q) begin
            nbuf   = mem_rdata;
            nstate = S_WR;
          end else if (last) begin
            nstate = S_DONE;
          end else begin
            nidx   = idx + ONE_IDX;
            nstate = S_RD;
          end
        end
      end
      S_WR: begin
        if (last) begin
          nstate = S_DONE;
        end else begin
          nidx   = idx + ONE_IDX;
          nstate = S_MEM;
        end
      end
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    n_busy      = (nstate != S_IDLE);
    n_done      = (nstate == S_DONE);
    n_rf_addr   = '0;
    n_rf_we     = 1'b0;
    n_rf_wdata  = '0;
    n_mem_req   = 1'b0;
    n_mem_we    = 1'b0;
    n_mem_addr  = '0;
    n_mem_wdata = '0;
    case (nstate)
      S_RD: n_rf_addr = nidx[RA_W-1:0];
      S_WR: begin
        n_rf_addr  = nidx[RA_W-1:0];
        n_rf_we    = 1'b1;
        n_rf_wdata = nbuf;
      end
      S_MEM: begin
        n_mem_req  = 1'b1;
        n_mem_we   = ~ndir;
        n_mem_addr = nbase + AW'(nidx);
        if (!ndir) n_mem_wdata = nbuf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      data_buf  <= '0;
      dir_q     <= 1'b0;
      base_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rf_addr   <= '0;
      rf_we     <= 1'b0;
      rf_wdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= nstate;
      idx       <= nidx;
      data_buf  <= nbuf;
      dir_q     <= ndir;
      base_q    <= nbase;
      busy      <= n_busy;
      done      <= n_done;
      rf_addr   <= n_rf_addr;
      rf_we     <= n_rf_we;
      rf_wdata  <= n_rf_wdata;
      mem_req   <= n_mem_req;
      mem_we    <= n_mem_we;
      mem_addr  <= n_mem_addr;
      mem_wdata <= n_mem_wdata;
    end
  end

endmodule
